// File: rtl/mem_port_arbiter.sv
// Two-requester (MCU / debugger) arbiter for a shared single-outstanding memory port.
// Round-robin on ties, debugger lock blocks MCU grants, per-access timeout abort.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mcu_req,
  input  logic        mcu_we,
  input  logic        mcu_byte,
  input  logic [31:0] mcu_addr,
  input  logic [31:0] mcu_wdata,
  output logic        mcu_ack,
  output logic        mcu_err,
  output logic [31:0] mcu_rdata,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic        dbg_byte,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ack,
  output logic        dbg_err,
  output logic [31:0] dbg_rdata,
  input  logic        dbg_lock,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_byte,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic [1:0]  grant
);

  // state  | meaning
  // IDLE   | no transaction; arbitrate eligible requests on each edge
  // ACCESS | command held on mem_*, waiting for mem_ack or timeout
  // RESP   | one-cycle ack or err to the grantee, no new grant

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

  state_t     state;
  logic [7:0] cnt;
  logic       last_dbg;
  logic       mcu_elig;
  logic       dbg_elig;
  logic       pick_dbg;

  always_comb begin
    mcu_elig = mcu_req & ~dbg_lock;
    dbg_elig = dbg_req;
    // On a tie the debugger wins only if the MCU was granted last
    pick_dbg = dbg_elig & (~mcu_elig | ~last_dbg);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      last_dbg  <= 1'b1;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_byte  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mcu_ack   <= 1'b0;
      mcu_err   <= 1'b0;
      mcu_rdata <= '0;
      dbg_ack   <= 1'b0;
      dbg_err   <= 1'b0;
      dbg_rdata <= '0;
      busy      <= 1'b0;
      grant     <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (mcu_elig || dbg_elig) begin
            state   <= ACCESS;
            mem_req <= 1'b1;
            busy    <= 1'b1;
            cnt     <= 8'd1;
            if (pick_dbg) begin
              mem_we    <= dbg_we;
              mem_byte  <= dbg_byte;
              mem_addr  <= dbg_addr;
              mem_wdata <= dbg_wdata;
              grant     <= 2'b10;
              last_dbg  <= 1'b1;
            end else begin
              mem_we    <= mcu_we;
              mem_byte  <= mcu_byte;
              mem_addr  <= mcu_addr;
              mem_wdata <= mcu_wdata;
              grant     <= 2'b01;
              last_dbg  <= 1'b0;
            end
          end
        end
        ACCESS: begin
          // A mem_ack on the timeout cycle still counts as a normal completion
          if (mem_ack) begin
            state   <= RESP;
            mem_req <= 1'b0;
            if (grant[1]) begin
              dbg_rdata <= mem_rdata;
              dbg_ack   <= 1'b1;
            end else begin
              mcu_rdata <= mem_rdata;
              mcu_ack   <= 1'b1;
            end
          end else if (cnt == TIMEOUT_CNT) begin
            state   <= RESP;
            mem_req <= 1'b0;
            if (grant[1]) begin
              dbg_rdata <= '0;
              dbg_err   <= 1'b1;
            end else begin
              mcu_rdata <= '0;
              mcu_err   <= 1'b1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          state   <= IDLE;
          cnt     <= '0;
          mcu_ack <= 1'b0;
          mcu_err <= 1'b0;
          dbg_ack <= 1'b0;
          dbg_err <= 1'b0;
          busy    <= 1'b0;
          grant   <= 2'b00;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand-written corner sequences,
// and randomized transactions checked against a transaction-level arbitration model.
module tb_mem_port_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mcu_req = 1'b0, mcu_we = 1'b0, mcu_byte = 1'b0;
  logic [31:0] mcu_addr = '0, mcu_wdata = '0;
  logic        mcu_ack, mcu_err;
  logic [31:0] mcu_rdata;
  logic        dbg_req = 1'b0, dbg_we = 1'b0, dbg_byte = 1'b0;
  logic [31:0] dbg_addr = '0, dbg_wdata = '0;
  logic        dbg_ack, dbg_err;
  logic [31:0] dbg_rdata;
  logic        dbg_lock = 1'b0;
  logic        mem_req, mem_we, mem_byte;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        busy;
  logic [1:0]  grant;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .mcu_req(mcu_req), .mcu_we(mcu_we), .mcu_byte(mcu_byte),
    .mcu_addr(mcu_addr), .mcu_wdata(mcu_wdata),
    .mcu_ack(mcu_ack), .mcu_err(mcu_err), .mcu_rdata(mcu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_byte(dbg_byte),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_err(dbg_err), .dbg_rdata(dbg_rdata),
    .dbg_lock(dbg_lock),
    .mem_req(mem_req), .mem_we(mem_we), .mem_byte(mem_byte),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .grant(grant)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: who was granted last, and each requester's last completion data
  logic        model_last_dbg = 1'b1;
  logic [31:0] model_mcu_rd = '0;
  logic [31:0] model_dbg_rd = '0;

  typedef struct {
    logic        m;
    logic        d;
    logic        lock;
    logic        we;
    logic        byt;
    logic [31:0] addr;
    int          ack_at;   // ACCESS cycle carrying mem_ack; 0 = never
    logic [31:0] rd;
    logic [1:0]  eg;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {23'd0, mem_req, mem_we, mem_byte, mcu_ack, mcu_err,
                        dbg_ack, dbg_err, busy, grant}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_mcu_rdata"}, mcu_rdata, 32'd0);
    chk({tag, "_dbg_rdata"}, dbg_rdata, 32'd0);
  endtask

  function automatic logic [1:0] model_winner(input logic m, input logic d,
                                              input logic lock, input logic last_dbg);
    logic m_ok;
    m_ok = m && !lock;
    if (m_ok && d) return last_dbg ? 2'b01 : 2'b10;
    if (m_ok)      return 2'b01;
    if (d)         return 2'b10;
    return 2'b00;
  endfunction

  // Called at a negedge with the DUT idle and the command fields already set.
  task automatic run_txn(input logic m, input logic d, input logic lock, input logic lock_mid,
                         input int ack_at, input logic [31:0] rd, input logic [1:0] eg);
    int   cyc;
    int   exp_cyc;
    logic to;
    mcu_req  = m;
    dbg_req  = d;
    dbg_lock = lock;
    @(negedge clk);
    if (eg == 2'b00) begin
      chk("nogrant_mem_req", mem_req, 0);
      chk("nogrant_busy", busy, 0);
      chk("nogrant_grant", grant, 0);
      mcu_req = 0; dbg_req = 0; dbg_lock = 0;
      @(negedge clk);
      return;
    end
    chk("grant_latency", mem_req, 1);
    chk("grant", grant, eg);
    chk("busy_access", busy, 1);
    chk("mem_addr", mem_addr, (eg == 2'b01) ? mcu_addr : dbg_addr);
    chk("mem_wdata", mem_wdata, (eg == 2'b01) ? mcu_wdata : dbg_wdata);
    chk("mem_we_byte", {mem_we, mem_byte},
        (eg == 2'b01) ? {mcu_we, mcu_byte} : {dbg_we, dbg_byte});
    model_last_dbg = (eg == 2'b10);
    dbg_lock = lock_mid;
    cyc = 0;
    while (mem_req === 1'b1 && cyc < 20) begin
      cyc++;
      mem_ack   = (cyc == ack_at);
      mem_rdata = rd;
      @(negedge clk);
      mem_ack = 0;
    end
    to      = !(ack_at >= 1 && ack_at <= TO);
    exp_cyc = to ? TO : ack_at;
    chk("access_cycles", cyc, exp_cyc);
    if (eg == 2'b01) model_mcu_rd = to ? 32'd0 : rd;
    else             model_dbg_rd = to ? 32'd0 : rd;
    chk("resp_busy", busy, 1);
    chk("mcu_ack", mcu_ack, (eg == 2'b01) && !to);
    chk("mcu_err", mcu_err, (eg == 2'b01) && to);
    chk("dbg_ack", dbg_ack, (eg == 2'b10) && !to);
    chk("dbg_err", dbg_err, (eg == 2'b10) && to);
    chk("mcu_rdata", mcu_rdata, model_mcu_rd);
    chk("dbg_rdata", dbg_rdata, model_dbg_rd);
    mcu_req = 0; dbg_req = 0; dbg_lock = 0;
    mem_rdata = $urandom;
    @(negedge clk);
    chk("idle_busy_grant", {busy, grant}, 3'b000);
    chk("idle_acks", {mcu_ack, mcu_err, dbg_ack, dbg_err}, 4'b0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //              m     d     lock  we    byte  addr           ack  rd             grant
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 2, 32'hCAFE_0001, 2'b01};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0014, 1, 32'hCAFE_0002, 2'b10};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0018, 4, 32'hCAFE_0003, 2'b01};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_001C, 0, 32'hCAFE_0004, 2'b10};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0040, 3, 32'hDEAD_BEEF, 2'b01};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0050, 1, 32'h1234_5678, 2'b10};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0060, 1, 32'h0BAD_0BAD, 2'b00};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0070, 2, 32'h7777_0000, 2'b10};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0080, 0, 32'h8888_0000, 2'b01};
    vecs[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0090, 1, 32'h9999_0000, 2'b10};

    #1;
    chk_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      mcu_we    = vecs[i].we;
      mcu_byte  = vecs[i].byt;
      mcu_addr  = vecs[i].addr;
      mcu_wdata = 32'h1111_0000 + i;
      dbg_we    = ~vecs[i].we;
      dbg_byte  = ~vecs[i].byt;
      dbg_addr  = vecs[i].addr ^ 32'h8000_0000;
      dbg_wdata = 32'h2222_0000 + i;
      run_txn(vecs[i].m, vecs[i].d, vecs[i].lock, 1'b0, vecs[i].ack_at, vecs[i].rd, vecs[i].eg);
    end

    // MCU access survives dbg_lock rising mid-transfer
    mcu_addr = 32'h0000_00A0; mcu_we = 0; mcu_byte = 0;
    run_txn(1'b1, 1'b0, 1'b0, 1'b1, 2, 32'h600D_600D, 2'b01);

    // Debugger byte write, reset pulsed mid-ACCESS, late mem_ack ignored
    dbg_we = 1; dbg_byte = 1; dbg_addr = 32'h0000_0100; dbg_wdata = 32'h0000_00A5;
    dbg_req = 1;
    @(negedge clk);
    chk("bw_mem_req", mem_req, 1);
    chk("bw_mem_addr", mem_addr, 32'h0000_0100);
    chk("bw_mem_wdata", mem_wdata, 32'h0000_00A5);
    chk("bw_we_byte", {mem_we, mem_byte}, 2'b11);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk_all_zero("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    dbg_req = 0;
    mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_ack = 0;
    chk("late_ack_ignored", {mem_req, busy, dbg_ack, dbg_err, mcu_ack, mcu_err}, 6'd0);
    chk("late_ack_rdata", dbg_rdata, 32'd0);
    model_last_dbg = 1'b1;
    model_mcu_rd = '0;
    model_dbg_rd = '0;

    // Lock: debugger served, MCU held off until lock drops
    dbg_we = 0; dbg_byte = 0; dbg_addr = 32'h0000_0200;
    mcu_we = 0; mcu_byte = 0; mcu_addr = 32'h0000_0300;
    dbg_lock = 1; mcu_req = 1; dbg_req = 1;
    @(negedge clk);
    chk("lock_grant_dbg", grant, 2'b10);
    chk("lock_dbg_addr", mem_addr, 32'h0000_0200);
    mem_ack = 1; mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    mem_ack = 0;
    chk("lock_dbg_ack", {dbg_ack, mcu_ack}, 2'b10);
    chk("lock_dbg_rdata", dbg_rdata, 32'h5555_AAAA);
    dbg_req = 0;
    @(negedge clk);
    @(negedge clk);
    chk("lock_blocks_mcu", {mem_req, busy}, 2'b00);
    dbg_lock = 0;
    @(negedge clk);
    chk("unlock_mcu_req", mem_req, 1);
    chk("unlock_grant", grant, 2'b01);
    chk("unlock_addr", mem_addr, 32'h0000_0300);
    mem_ack = 1; mem_rdata = 32'h0F0F_0F0F;
    @(negedge clk);
    mem_ack = 0;
    chk("unlock_mcu_ack", {mcu_ack, mcu_err, dbg_ack}, 3'b100);
    chk("unlock_mcu_rdata", mcu_rdata, 32'h0F0F_0F0F);
    mcu_req = 0;
    @(negedge clk);
    model_last_dbg = 1'b0;
    model_mcu_rd = 32'h0F0F_0F0F;
    model_dbg_rd = 32'h5555_AAAA;

    for (int n = 0; n < 40; n++) begin
      logic       m, d, lock;
      logic [1:0] eg;
      m    = 1'($urandom_range(0, 1));
      d    = 1'($urandom_range(0, 1));
      lock = ($urandom_range(0, 3) == 0);
      mcu_we = 1'($urandom); mcu_byte = 1'($urandom);
      mcu_addr = $urandom; mcu_wdata = $urandom;
      dbg_we = 1'($urandom); dbg_byte = 1'($urandom);
      dbg_addr = $urandom; dbg_wdata = $urandom;
      eg = model_winner(m, d, lock, model_last_dbg);
      run_txn(m, d, lock, 1'($urandom_range(0, 1)), $urandom_range(0, 5),
              $urandom | 32'h1, eg);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
